mod_mem_access: RTL
===================

# mod_mem_access

Data-memory access unit for the MEM stage of the pipeline CPU. It takes load/store requests, checks alignment, and drives a req/ack handshake to data memory. It extracts byte, halfword or word lanes from read data and sign- or zero-extends them to 32 bits. For stores it narrows and replicates write data with byte enables, and it stalls the pipeline while an access is in flight.

## Interface
- `ADDR_W`, 32, byte-address width of op_addr and mem_addr
- `clk`  in  1  pipeline clock; all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `op_valid`  in  1  MEM stage holds a load/store this cycle
- `op_write`  in  1  1 = store, 0 = load
- `op_size`  in  2  00 byte, 01 half, 10 word, 11 illegal
- `op_unsigned`  in  1  loads only: 1 = zero-extend (LBU/LHU), 0 = sign-extend
- `op_addr`  in  ADDR_W  byte address
- `op_wdata`  in  32  store data (low bits significant for byte/half)
- `stall`  out  1  combinational; freeze pipeline
- `misaligned`  out  1  combinational; address exception, no access issued
- `rdata`  out  32  registered, extended load result
- `rdata_valid`  out  1  registered one-cycle pulse with rdata (loads only)
- `bus_err`  out  1  registered one-cycle pulse on timeout (see Configuration)
- `mem_req`  out  1  registered request
- `mem_we`  out  1  registered write strobe
- `mem_addr`  out  ADDR_W  registered word address, bits [1:0] = 00
- `mem_be`  out  4  registered byte enables, bit n = bits [8n+7:8n]
- `mem_wdata`  out  32  registered lane-replicated store data
- `mem_ack`  in  1  memory accepted/completed the access
- `mem_rdata`  in  32  read word, valid when mem_ack = 1 for a load

## Operation
- States: IDLE, REQ, DONE.
- Little-endian lanes: byte lane = addr[1:0]; half lane = addr[1].
- Alignment check in IDLE: half needs addr[0]=0; word needs addr[1:0]=00; size 11 is always misaligned.
- IDLE:
  - op_valid and misaligned: misaligned=1, stall=0, stay IDLE, memory untouched.
  - op_valid and aligned: stall=1. At the next edge, latch the request, drive mem_* and go to REQ.
- REQ: stall=1.
  - mem_req and mem_we/addr/be/wdata hold stable until mem_ack is sampled high.
  - On ack: mem_req/mem_we clear and the state moves to DONE.
  - For a load, rdata is loaded at the same edge and rdata_valid is set.
- DONE: stall=0 and op_valid is ignored, because the held instruction advances at this edge. rdata_valid clears and the state returns to IDLE.
- Load data extraction:
  - byte: mem_rdata[8a+7:8a], extended from bit 7.
  - half: mem_rdata[16h+15:16h], extended from bit 15.
  - word: passed through unchanged.
- Extension: zero if op_unsigned=1 or the top bit is 0; otherwise upper bits are all ones.
- Store mem_wdata:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: unchanged
- Store mem_be:
  - byte: 0001 << a
  - half: 0011 or 1100
  - word: 1111
- Loads: mem_be = 1111, mem_we = 0.
- rdata holds its last value between loads; stores never change rdata or pulse rdata_valid.

## Timing
- Reset values: state IDLE; mem_req, mem_we, mem_addr, mem_be, mem_wdata, rdata, rdata_valid, bus_err all 0. stall and misaligned are forced to 0 while rst=1.
- Best case:
  - cycle 0: op_valid seen, stall=1.
  - cycle 1: mem_req=1; ack sampled at the end of cycle 1.
  - cycle 2: DONE, rdata_valid=1, stall=0.
- Each wait cycle of mem_ack adds one stall cycle. Occupancy is 3 + wait cycles.
- mem_ack while mem_req=0 is ignored.
- Back-to-back accesses: a new op_valid is accepted only in IDLE, so there is at least one bubble cycle (DONE) between accesses.
- rst in REQ: mem_req drops at that edge, no result is produced, and the state goes to IDLE. Memory tolerates the abandoned request.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - An 8-bit counter clears on REQ entry and increments each REQ cycle without ack.
  - After 255 unacked REQ cycles, mem_req drops and the state goes to DONE.
  - In that DONE cycle bus_err pulses for one cycle, and rdata=0 with rdata_valid=1 for loads.
- Undefined: REQ waits indefinitely, bus_err is tied to 0, and no counter is built.

## Test plan
- LB at addr 0x103, mem_rdata=0x80FF_1234 with 0 wait cycles -> mem_addr=0x100, mem_be=1111; cycle 2 rdata=0xFFFF_FF80, rdata_valid pulse, stall high cycles 0-1 only.
- LHU at 0x202, mem_rdata=0x9ABC_0000 with 3 wait cycles -> rdata=0x0000_9ABC; mem_req is stable for 4 cycles; stall stays high through the last REQ cycle.
- SB at 0x301 with wdata=0x1234_56A5 -> mem_we=1, mem_be=0010, mem_wdata=0xA5A5_A5A5, no rdata_valid.
- LW at 0x402 and SH at 0x001 -> misaligned=1 in the same cycle, stall=0, mem_req never asserted.
- rst in the second REQ cycle of an LW -> mem_req low the next cycle, rdata_valid never pulses; a following LW completes normally.
- With MEM_TIMEOUT_EN, LW with mem_ack held 0 -> after 255 REQ cycles, a bus_err pulse, rdata=0, stall released. Without the macro, stall is still high at cycle 1000.

Source files
------------

// File: rtl/mod_mem_access.sv
// mod_mem_access: MEM-stage load/store unit with alignment check, req/ack memory handshake and lane extract/replicate.
// Optional MEM_TIMEOUT_EN adds a 255-cycle ack timeout that reports bus_err.
module mod_mem_access #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic              op_write,
    input  logic [1:0]        op_size,
    input  logic              op_unsigned,
    input  logic [ADDR_W-1:0] op_addr,
    input  logic [31:0]       op_wdata,
    output logic              stall,
    output logic              misaligned,
    output logic [31:0]       rdata,
    output logic              rdata_valid,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rdata_valid_q, rdata_valid_d;
    logic [1:0]        size_q, size_d;
    logic [1:0]        lane_q, lane_d;
    logic              uns_q, uns_d;
    logic              addr_bad, accept, timeout;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [31:0]       load_ext;

    assign addr_bad   = (op_size == 2'b11) || (op_size == 2'b01 && op_addr[0]) ||
                        (op_size == 2'b10 && op_addr[1:0] != 2'b00);
    assign accept     = state_q == IDLE && op_valid && !addr_bad;
    assign misaligned = !rst && state_q == IDLE && op_valid && addr_bad;
    assign stall      = !rst && (accept || state_q == REQ);

    assign byte_v   = mem_rdata[{lane_q, 3'b000} +: 8];
    assign half_v   = mem_rdata[{lane_q[1], 4'b0000} +: 16];
    assign load_ext = size_q == 2'b00 ? {{24{!uns_q && byte_v[7]}}, byte_v} :
                      size_q == 2'b01 ? {{16{!uns_q && half_v[15]}}, half_v} : mem_rdata;

`ifdef MEM_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       bus_err_q;
    // cnt_q counts completed unacked REQ cycles; the 255th one aborts
    assign cnt_d   = (state_q == REQ && !mem_ack) ? cnt_q + 8'd1 : 8'd0;
    assign timeout = state_q == REQ && !mem_ack && cnt_q == 8'd254;
    assign bus_err = bus_err_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= 8'd0;
            bus_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bus_err_q <= timeout;
        end
    end
`else
    assign timeout = 1'b0;
    assign bus_err = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_be_d      = mem_be_q;
        mem_wdata_d   = mem_wdata_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        size_d        = size_q;
        lane_d        = lane_q;
        uns_d         = uns_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d     = REQ;
                mem_req_d   = 1'b1;
                mem_we_d    = op_write;
                mem_addr_d  = {op_addr[ADDR_W-1:2], 2'b00};
                mem_be_d    = !op_write ? 4'b1111 :
                              op_size == 2'b00 ? 4'b0001 << op_addr[1:0] :
                              op_size == 2'b01 ? (op_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
                mem_wdata_d = op_size == 2'b00 ? {4{op_wdata[7:0]}} :
                              op_size == 2'b01 ? {2{op_wdata[15:0]}} : op_wdata;
                size_d      = op_size;
                lane_d      = op_addr[1:0];
                uns_d       = op_unsigned;
            end
            REQ: if (mem_ack || timeout) begin
                state_d       = DONE;
                mem_req_d     = 1'b0;
                mem_we_d      = 1'b0;
                rdata_valid_d = !mem_we_q;
                rdata_d       = mem_we_q ? rdata_q : (mem_ack ? load_ext : 32'd0);
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_be_q      <= 4'd0;
            mem_wdata_q   <= 32'd0;
            rdata_q       <= 32'd0;
            rdata_valid_q <= 1'b0;
            size_q        <= 2'd0;
            lane_q        <= 2'd0;
            uns_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_be_q      <= mem_be_d;
            mem_wdata_q   <= mem_wdata_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            size_q        <= size_d;
            lane_q        <= lane_d;
            uns_q         <= uns_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_be      = mem_be_q;
    assign mem_wdata   = mem_wdata_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
endmodule
